muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that owns the HI/LO register pair for the single-cycle MIPS core. It is the responder for the multiply/divide and HI/LO-read side of the main controller. It accepts MULT/MULTU/DIV/DIVU requests with a start pulse, computes over multiple cycles while asserting busy (the core stalls on busy), and exposes HI/LO for MFHI/MFLO reads. MTHI/MTLO writes also land here.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  request strobe, sampled only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- wr_hi  input  1  MTHI write strobe
- wr_lo  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress (state != IDLE); core must stall
- done  output  1  registered one-cycle pulse; HI/LO hold new result this cycle
- hi  output  WIDTH  HI register (product high half / remainder)
- lo  output  WIDTH  LO register (product low half / quotient)

## Operation
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0.
- States:
  - IDLE -> CALC on start. Operands are latched as magnitudes for signed ops. Result signs are recorded.
  - CALC: one radix-2 step per cycle for WIDTH cycles, using shift-add multiply or restoring divide. After the last step -> FIX.
  - FIX: apply sign correction, write hi/lo, pulse done, then -> IDLE.
- Signed rules:
  - MULT: the 64-bit product is negated when sign(a) xor sign(b).
  - DIV: the quotient is negated when sign(a) xor sign(b). The remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0. Magnitude arithmetic is WIDTH-bit unsigned, and the wrap is intended.
- Divide by zero (b==0, DIV or DIVU): detected at start. CALC is skipped (IDLE -> FIX). Result is lo=0xFFFFFFFF, hi=a unmodified.
- start while busy: ignored, and the operation in flight is unaffected.
- wr_hi/wr_lo in IDLE: the register is written at the clock edge. Both may be asserted together.
- wr_hi/wr_lo while busy: ignored.
- Writes and start in the same IDLE cycle: start wins, and the writes are dropped.
- done and a new start in the same cycle: accepted, because the state is already IDLE.
- hi/lo change only at the FIX edge or on accepted writes. They are stable at all other times, including throughout CALC.
- Reset asserted mid-operation: abort immediately to the reset values. No partial result is written.

## Timing
- Edge E0 samples start. Edges E1..E32 perform the 32 CALC steps. E33 writes hi/lo and sets done.
- busy is high from after E0 through E33, i.e. 33 cycles.
- done is high for exactly the one cycle after E33.
- Divide by zero: busy for 1 cycle; done in the cycle after E1.
- MTHI/MTLO: new value is visible the cycle after the write edge.
- busy is a decode of the state register with no combinational path from inputs. done is a flop.

## Configuration
- MULDIV_FASTMUL_EN defined:
  - MULT/MULTU use a single-cycle WIDTH x WIDTH multiplier and go IDLE -> FIX directly.
  - busy lasts 1 cycle; done follows E1.
- MULDIV_FASTMUL_EN undefined: multiplies use the iterative 32-step path above.
- Division is iterative in both builds.

## Structure
- Shared package muldiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum: IDLE, CALC, FIX
  - MULDIV_STEPS = WIDTH
  - controller funct codes for MFHI/MFLO/MTHI/MTLO/MULT/DIV, shared with the decoder
- One sub-module, muldiv_fixup: combinational sign correction. It takes the raw 64-bit magnitude result, the two recorded sign bits and the op, and returns the final {hi, lo}.
- The FSM, counter and shift registers stay in muldiv_unit.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 busy cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Repeat with MULDIV_FASTMUL_EN: done after 1 busy cycle.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> busy 1 cycle; lo=0xFFFFFFFF, hi=0x12345678.
- Start MULTU 5x6:
  - wr_hi=1, wdata=0xAAAA at cycle 5 and start again at cycle 10 -> both ignored; hi:lo=0:30 at done.
  - Then reset pulsed low during a second op at cycle 12 -> busy=0, hi=lo=0, done never pulses.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit and the main decoder.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_STEPS = MULDIV_WIDTH;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_fixup.sv
// Sign correction of the raw magnitude result into final {hi, lo}.
module muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] raw,
    input  logic               neg,
    input  logic               rem_neg,
    input  op_e                op,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;
    logic [2*WIDTH-1:0] prod_neg;

    assign rem      = raw[2*WIDTH-1:WIDTH];
    assign quot     = raw[WIDTH-1:0];
    assign prod_neg = -raw;

    always_comb begin
        hi = rem;
        lo = quot;
        case (op)
            OP_MULT: if (neg) {hi, lo} = prod_neg;
            OP_DIV: begin
                hi = rem_neg ? -rem : rem;
                lo = neg ? -quot : quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Define MULDIV_FASTMUL_EN for a
// single-cycle multiplier; division is always iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    op_e              op_in;
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign op_in   = op_e'(op);
    assign sa      = ((op_in == OP_MULT) || (op_in == OP_DIV)) && a[WIDTH-1];
    assign sb      = ((op_in == OP_MULT) || (op_in == OP_DIV)) && b[WIDTH-1];
    assign mag_a   = sa ? -a : a;
    assign mag_b   = sb ? -b : b;
    assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : '0);
    assign div_shift = {acc_q, mq_q[WIDTH-1]};

`ifdef MULDIV_FASTMUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    muldiv_fixup #(.WIDTH(WIDTH)) u_fixup (
        .raw     ({acc_q, mq_q}),
        .neg     (neg_q),
        .rem_neg (rneg_q),
        .op      (op_q),
        .hi      (fix_hi),
        .lo      (fix_lo)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op_in;
                    cnt_d  = '0;
                    neg_d  = sa ^ sb;
                    rneg_d = sa;
                    acc_d  = '0;
                    mq_d   = mag_a;
                    dvs_d  = mag_b;
                    state_d = CALC;
                    // Zeroed signs make the fixup pass {a, all-ones} through untouched.
                    if (op_in[1] && (b == '0)) begin
                        acc_d   = a;
                        mq_d    = '1;
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = FIX;
                    end
`ifdef MULDIV_FASTMUL_EN
                    else if (!op_in[1]) begin
                        {acc_d, mq_d} = fast_prod;
                        state_d = FIX;
                    end
`endif
                end else begin
                    if (wr_hi) hi_d = wdata;
                    if (wr_lo) lo_d = wdata;
                end
            end
            CALC: begin
                if (op_q[1]) begin
                    if (div_shift >= {1'b0, dvs_q}) begin
                        acc_d = WIDTH'(div_shift - {1'b0, dvs_q});
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            acc_q   <= '0;
            mq_q    <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit; honours MULDIV_FASTMUL_EN.
module tb_muldiv_unit;

`ifdef MULDIV_FASTMUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    logic [1:0]  long_op;
    logic [31:0] long_a;
    logic [31:0] long_b;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered just after a negedge; returns at the negedge where done is high.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_busy,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            if (n == 1) check({tag, "_done_low"}, {31'b0, done}, 32'd0);
            if (n == exp_busy / 2 + 1) begin
                check({tag, "_hi_stable"}, hi, mhi);
                check({tag, "_lo_stable"}, lo, mlo);
            end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        mhi = ehi;
        mlo = elo;
    endtask

    task automatic write_hl(input string tag, input logic whi, input logic wlo, input logic [31:0] d);
        wr_hi = whi; wr_lo = wlo; wdata = d;
        @(posedge clk);
        #1 wr_hi = 1'b0; wr_lo = 1'b0;
        if (whi) mhi = d;
        if (wlo) mlo = d;
        @(negedge clk);
        check({tag, "_hi"}, hi, mhi);
        check({tag, "_lo"}, lo, mlo);
    endtask

    initial begin
        int k;
        int done_seen;
`ifdef MULDIV_FASTMUL_EN
        long_op = 2'b11; long_a = 32'd30; long_b = 32'd1;
`else
        long_op = 2'b01; long_a = 32'd5;  long_b = 32'd6;
`endif
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        write_hl("mthi", 1'b1, 1'b0, 32'h1111_2222);
        write_hl("mtlo", 1'b0, 1'b1, 32'h3333_4444);
        write_hl("mthilo", 1'b1, 1'b1, 32'hDEAD_BEEF);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_BUSY, 32'hFFFF_FFFE, 32'h0000_0001);
        // Back-to-back: each start below lands in the done cycle of the previous op.
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, MUL_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_negneg", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_BUSY, 32'h0, 32'h1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, DIV_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negdvs", 2'b10, 32'd7, 32'hFFFF_FFFE, DIV_BUSY, 32'd1, 32'hFFFF_FFFD);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_BUSY, 32'h0, 32'h8000_0000);
        run_op("divu", 2'b11, 32'd100, 32'd7, DIV_BUSY, 32'd2, 32'd14);
        run_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("div_zero_neg", 2'b10, 32'h8000_0005, 32'd0, 1, 32'h8000_0005, 32'hFFFF_FFFF);

        @(negedge clk);
        check("idle_done_clear", {31'b0, done}, 32'd0);

        // start and write in the same cycle: writes dropped
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h5555_5555;
        run_op("start_vs_wr", 2'b01, 32'd2, 32'd3, MUL_BUSY, 32'd0, 32'd6);
        wr_hi = 1'b0; wr_lo = 1'b0;
        @(negedge clk);

        // write at cycle 5 and start at cycle 10 of a running op: both ignored
        op = long_op; a = long_a; b = long_b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 wr_hi = 1'b1; wdata = 32'h0000_AAAA;
        @(posedge clk);
        #1 wr_hi = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        @(negedge clk);
        while (!done && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("busy_ign_done", {31'b0, done}, 32'd1);
        check("busy_ign_hi", hi, 32'd0);
        check("busy_ign_lo", lo, 32'd30);
        mhi = 32'd0; mlo = 32'd30;
        @(negedge clk);
        check("busy_ign_no_restart", {31'b0, busy}, 32'd0);

        write_hl("pre_rst", 1'b1, 1'b0, 32'h0000_CAFE);

        // reset pulsed low at cycle 12 of a running op
        op = long_op; a = long_a; b = long_b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        mhi = '0; mlo = '0;
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        check("midrst_hi_after", hi, 32'd0);
        check("midrst_lo_after", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
